uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver, 8N1 format (1 start bit, 8 data bits LSB first, 1 stop bit, no parity), oversampled at `CLKS_PER_BIT` system clocks per bit. It is the receive-side counterpart of the team's UART transmitter and shares its bit-timing parameter. It delivers each received byte as a one-cycle `rx_dv` strobe to the host-side logic.

## Interface
- `CLKS_PER_BIT`, default 10417: system clocks per serial bit. Legal values are ≥ 4.
- `clock`  in  1  System clock. All state updates on its rising edge.
- `reset`  in  1  Asynchronous, active-high. Forces every register to its reset value immediately.
- `rx_serial`  in  1  Serial line, idle high. Asynchronous to `clock`.
- `rx_data`  out  8  Last correctly framed byte. Holds its value until the next good byte.
- `rx_dv`  out  1  One-cycle pulse: `rx_data` has just been updated.
- `rx_active`  out  1  High while a frame is in progress (START through STOP).
- `rx_frame_err`  out  1  One-cycle pulse: the stop bit was sampled low.

## Operation
- **Input synchronizer.** `rx_serial` passes through two flops, both reset to 1. The output `rx_sync` is the only version of the line the FSM uses.
- **Half-bit constant.** `H = (CLKS_PER_BIT-1)/2`, using integer division.
- **Counter.** The bit counter is `$clog2(CLKS_PER_BIT)+1` bits wide and never exceeds `CLKS_PER_BIT-1`. A separate 3-bit index selects the data bit.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Any unused encoding goes to IDLE.
- **IDLE**
  - Holds counter and index at 0.
  - If `rx_sync==0`: set `rx_active<=1` and go to START.
- **START**
  - While counter < H: increment the counter.
  - When counter == H, sample `rx_sync` once:
    - 0 (valid start): clear counter, go to DATA.
    - 1 (glitch): set `rx_active<=0`, go to IDLE. No output pulse.
- **DATA**
  - While counter < `CLKS_PER_BIT-1`: increment the counter.
  - Otherwise:
    - Clear the counter.
    - Write `shift[index] <= rx_sync`.
    - If index < 7: increment the index. If index == 7: reset the index to 0 and go to STOP.
- **STOP**
  - Counts to `CLKS_PER_BIT-1` in the same way as DATA, then samples `rx_sync` and sets `rx_active<=0`.
  - Sample = 1: `rx_data<=shift`, `rx_dv<=1`, go to IDLE.
  - Sample = 0: `rx_frame_err<=1`, `rx_data` unchanged, go to BREAK.
- **BREAK**
  - Stays here until `rx_sync==1`, then goes to IDLE.
  - Purpose: a held-low line must not be decoded as repeated `0x00` frames.
- **Pulses.** `rx_dv` and `rx_frame_err` default to 0 every cycle. They are never high together.
- **Reset values.** `rx_data=8'h00`, `rx_dv=0`, `rx_active=0`, `rx_frame_err=0`, state IDLE, counter 0, index 0, shift register 0, synchronizer flops 1.
- **Reset mid-frame.** The frame is discarded and no pulse is produced. After reset releases, reception resumes at the next falling edge seen in IDLE. If the line is low when reset releases, the receiver treats it as a start bit.

## Timing
- **Start detection.** Let S be the edge that first captures `rx_serial` low. IDLE detects the start at edge E0 = S+2 (synchronizer latency).
- **Start validation.** The start bit is checked at E0+H+1.
- **Data sampling.** Data bit k (k = 0..7) is sampled at E0+H+1+(k+1)·`CLKS_PER_BIT`.
- **Stop sampling.** The stop bit is sampled at E0+H+1+9·`CLKS_PER_BIT`. `rx_dv` (or `rx_frame_err`) is high for the cycle following that edge.
- **`rx_active`.** High from E0 to the stop-sample edge, exclusive.
- **Back-to-back frames.** After a good stop sample, the FSM is in IDLE from mid-stop-bit. A start bit immediately following the stop bit is therefore detected with no lost frames.
- **Throughput.** One byte per 10 bit-times. There is no internal buffering: the consumer must capture `rx_data` within 9 bit-times of `rx_dv`, or the next good byte overwrites it.

## Test plan
All scenarios use `CLKS_PER_BIT=4`, so H=1.
1. **Single byte.** Drive `0x A5` as 8N1, 4 clocks per bit. Expect:
   - `rx_dv` high for exactly 1 cycle, at E0+38.
   - `rx_data=0xA5`.
   - `rx_active` high for 38 cycles.
   - `rx_frame_err` stays 0.
2. **Back-to-back frames.** Drive `0x00`, `0xFF`, `0x3C` with no idle gap. Expect three `rx_dv` pulses, 40 cycles apart, with data `0x00`, `0xFF`, `0x3C`.
3. **Start glitch.** Drive `rx_serial` low for 1 clock, then high. Expect:
   - `rx_active` high for 2 cycles.
   - No `rx_dv` and no `rx_frame_err`.
   - `rx_data` unchanged.
4. **Framing error and break.** Send `0x55` with the stop bit low, then hold the line low for 100 clocks.
   - Expect one `rx_frame_err` pulse, no `rx_dv`, and `rx_data` keeps its prior value.
   - Then release the line high and send `0x81`: expect `rx_dv` with `rx_data=0x81`.
5. **Reset mid-frame.** Assert `reset` for 1 cycle during data bit 3 of `0xF0`, with the line then idling high. Expect:
   - All outputs at reset values immediately, without waiting for a clock edge.
   - No pulse for the aborted frame.
   - A subsequent `0x5A` is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with start-glitch rejection and break hold-off
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_dv,
    output logic       rx_active,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            dv_q, dv_d;
    logic            active_q, active_d;
    logic            err_q, err_d;
    logic            rx_sync;

    assign sync1_d = rx_serial;
    assign sync2_d = sync1_q;
    assign rx_sync = sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_sync) state_d = S_START;
            S_START: if (cnt_q == HALF) state_d = rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (cnt_q == LAST && idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (cnt_q == LAST) state_d = rx_sync ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_sync) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync) active_d = 1'b1;
            end
            S_START: begin
                if (cnt_q < HALF) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (rx_sync) active_d = 1'b0;
                end
            end
            S_DATA: begin
                if (cnt_q < LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    idx_d          = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q < LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    if (rx_sync) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_BREAK: cnt_d = '0;
            default: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_dv        = dv_q;
    assign rx_active    = active_q;
    assign rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx at 4 clocks per bit
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clock;
    logic       reset;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic       rx_active;
    logic       rx_frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_count = 0;
    int err_count = 0;
    int act_count = 0;
    int start_cyc;
    logic [7:0] exp_q[$];
    int dv_cycles[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_serial   (rx_serial),
        .rx_data     (rx_data),
        .rx_dv       (rx_dv),
        .rx_active   (rx_active),
        .rx_frame_err(rx_frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_dv and tallies pulses/activity.
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_active) act_count++;
            if (rx_frame_err) err_count++;
            if (rx_dv && rx_frame_err) check("dv_err_overlap", 1, 0);
            if (rx_dv) begin
                dv_count++;
                dv_cycles.push_back(cyc);
                check("scoreboard_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx_serial = stop_bit;
        repeat (CPB) @(negedge clock);
        rx_serial = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        rx_serial = 1'b1;
        #1;
        check("reset_rx_data", {24'h0, rx_data}, 0);
        check("reset_rx_dv", rx_dv, 0);
        check("reset_rx_active", rx_active, 0);
        check("reset_rx_frame_err", rx_frame_err, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single byte with exact latency and active-window length
        act_count = 0; dv_count = 0; err_count = 0; dv_cycles.delete();
        exp_q.push_back(8'hA5);
        start_cyc = cyc;
        send_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clock);
        check("t1_dv_count", dv_count, 1);
        check("t1_active_cycles", act_count, 38);
        check("t1_frame_err", err_count, 0);
        check("t1_dv_count_q", dv_cycles.size(), 1);
        if (dv_cycles.size() == 1) check("t1_dv_latency", dv_cycles[0] - start_cyc, 41);

        // Back-to-back frames
        dv_count = 0; dv_cycles.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (10) @(negedge clock);
        check("t2_dv_count", dv_count, 3);
        if (dv_cycles.size() == 3) begin
            check("t2_gap_a", dv_cycles[1] - dv_cycles[0], 40);
            check("t2_gap_b", dv_cycles[2] - dv_cycles[1], 40);
        end

        // Start glitch
        act_count = 0; dv_count = 0; err_count = 0;
        rx_serial = 1'b0;
        @(negedge clock);
        rx_serial = 1'b1;
        repeat (20) @(negedge clock);
        check("t3_active_cycles", act_count, 2);
        check("t3_dv_count", dv_count, 0);
        check("t3_err_count", err_count, 0);
        check("t3_rx_data", {24'h0, rx_data}, 32'h3C);

        // Framing error followed by a held-low break
        dv_count = 0; err_count = 0;
        send_byte(8'h55, 1'b0);
        rx_serial = 1'b0;
        repeat (100) @(negedge clock);
        check("t4_err_count", err_count, 1);
        check("t4_dv_count", dv_count, 0);
        check("t4_rx_data", {24'h0, rx_data}, 32'h3C);
        rx_serial = 1'b1;
        repeat (10) @(negedge clock);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        repeat (10) @(negedge clock);
        check("t4_dv_after_break", dv_count, 1);
        check("t4_err_after_break", err_count, 1);

        // Reset during data bit 3 of 0xF0
        dv_count = 0; err_count = 0;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            rx_serial = 1'b0;
            repeat (CPB) @(negedge clock);
        end
        rx_serial = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        check("t5_active_before", rx_active, 1);
        reset = 1'b1;
        rx_serial = 1'b1;
        #1;
        check("t5_async_rx_data", {24'h0, rx_data}, 0);
        check("t5_async_rx_dv", rx_dv, 0);
        check("t5_async_rx_active", rx_active, 0);
        check("t5_async_rx_frame_err", rx_frame_err, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        check("t5_no_pulse_dv", dv_count, 0);
        check("t5_no_pulse_err", err_count, 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        repeat (10) @(negedge clock);
        check("t5_dv_count", dv_count, 1);
        check("t5_rx_data_hold", {24'h0, rx_data}, 32'h5A);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
